// File: rtl/vdp_pkg.sv
// Shared VDP types: VRAM address width, read-owner tags and the CPU buffer states.
package vdp_pkg;

  localparam int VRAM_AW = 14;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_SPR  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

  typedef enum logic [1:0] {
    CPU_IDLE   = 2'd0,
    CPU_PEND   = 2'd1,
    CPU_RDWAIT = 2'd2
  } cpu_state_t;

endpackage

// File: rtl/vram_cpu_port.sv
// One-entry CPU access buffer with starvation counter; read data returns 2 cycles after grant.
// Strobes arriving while the buffer is occupied are dropped (busy is the CPU's backpressure).
module vram_cpu_port
  import vdp_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 8,
  parameter int AW           = VRAM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_wr,
  input  logic          cpu_rd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  input  logic          gnt,
  input  logic          rd_ret,
  input  logic [7:0]    vram_rdata,
  output logic          pend,
  output logic          starved,
  output logic [AW-1:0] addr,
  output logic [7:0]    wdata,
  output logic          is_wr,
  output logic          busy,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_rd_valid
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(CPU_MAX_WAIT);

  cpu_state_t    r_state;
  cpu_state_t    w_next;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata;
  logic          r_is_wr;
  logic [3:0]    r_wait_cnt;
  logic [7:0]    r_cpu_rdata;
  logic          w_strobe;
  logic          w_capture;
  logic          w_rd_done;

  assign w_strobe  = cpu_wr | cpu_rd;
  assign w_capture = (r_state == CPU_IDLE) && w_strobe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= CPU_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CPU_IDLE:   if (w_strobe) w_next = CPU_PEND;
      CPU_PEND:   if (gnt) w_next = r_is_wr ? CPU_IDLE : CPU_RDWAIT;
      CPU_RDWAIT: if (rd_ret) w_next = CPU_IDLE;
      default:    w_next = CPU_IDLE;
    endcase
  end

  always_comb begin
    pend      = (r_state == CPU_PEND);
    busy      = (r_state != CPU_IDLE);
    w_rd_done = (r_state == CPU_RDWAIT) && rd_ret;
    starved   = pend && (r_wait_cnt >= LP_MAX_WAIT);
  end

  // A simultaneous write+read strobe keeps the write; the read is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_is_wr <= 1'b0;
    end else if (w_capture) begin
      r_addr  <= cpu_addr;
      r_wdata <= cpu_wdata;
      r_is_wr <= cpu_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state != CPU_PEND) || gnt) begin
      r_wait_cnt <= 4'd0;
    end else if (r_wait_cnt != 4'hF) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rdata <= 8'd0;
    end else if (w_rd_done) begin
      r_cpu_rdata <= vram_rdata;
    end
  end

  // Bypass so the new byte is visible in the same cycle as the valid pulse.
  assign cpu_rdata    = w_rd_done ? vram_rdata : r_cpu_rdata;
  assign cpu_rd_valid = w_rd_done;
  assign addr         = r_addr;
  assign wdata        = r_wdata;
  assign is_wr        = r_is_wr;

endmodule

// File: rtl/vram_arbiter.sv
// Fixed-priority VRAM arbiter (starved CPU > bg > spr > CPU), one grant per cycle, registered VRAM port.
// Reads return tagged 2 cycles after grant; losers hold req/addr and retry, grants never depend on read data.
module vram_arbiter
  import vdp_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 8,
  parameter int AW           = VRAM_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bg_req,
  input  logic [AW-1:0] bg_addr,
  output logic          bg_gnt,
  output logic          bg_rvalid,
  input  logic          spr_req,
  input  logic [AW-1:0] spr_addr,
  output logic          spr_gnt,
  output logic          spr_rvalid,
  input  logic          cpu_wr,
  input  logic          cpu_rd,
  input  logic [AW-1:0] cpu_addr,
  input  logic [7:0]    cpu_wdata,
  output logic          cpu_busy,
  output logic [7:0]    cpu_rdata,
  output logic          cpu_rd_valid,
  output logic [AW-1:0] vram_addr,
  output logic          vram_we,
  output logic [7:0]    vram_wdata,
  input  logic [7:0]    vram_rdata
);

  logic          w_cpu_pend;
  logic          w_cpu_starved;
  logic [AW-1:0] w_cpu_addr;
  logic [7:0]    w_cpu_wdata;
  logic          w_cpu_is_wr;
  logic          w_cpu_gnt;
  logic          w_bg_gnt;
  logic          w_spr_gnt;
  logic          w_any_gnt;
  logic [AW-1:0] w_gnt_addr;
  owner_t        w_owner;
  owner_t        r_tag1;
  owner_t        r_tag2;
  logic [AW-1:0] r_vram_addr;
  logic          r_vram_we;
  logic [7:0]    r_vram_wdata;

  vram_cpu_port #(
    .CPU_MAX_WAIT (CPU_MAX_WAIT),
    .AW           (AW)
  ) u_cpu_port (
    .clk          (clk),
    .rst          (rst),
    .cpu_wr       (cpu_wr),
    .cpu_rd       (cpu_rd),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .gnt          (w_cpu_gnt),
    .rd_ret       (r_tag2 == OWN_CPU),
    .vram_rdata   (vram_rdata),
    .pend         (w_cpu_pend),
    .starved      (w_cpu_starved),
    .addr         (w_cpu_addr),
    .wdata        (w_cpu_wdata),
    .is_wr        (w_cpu_is_wr),
    .busy         (cpu_busy),
    .cpu_rdata    (cpu_rdata),
    .cpu_rd_valid (cpu_rd_valid)
  );

  // Grants are suppressed during reset so nothing is launched into a pipeline being cleared.
  always_comb begin
    w_bg_gnt   = 1'b0;
    w_spr_gnt  = 1'b0;
    w_cpu_gnt  = 1'b0;
    w_owner    = OWN_NONE;
    w_gnt_addr = r_vram_addr;
    if (!rst) begin
      if (w_cpu_starved) begin
        w_cpu_gnt  = 1'b1;
        w_owner    = OWN_CPU;
        w_gnt_addr = w_cpu_addr;
      end else if (bg_req) begin
        w_bg_gnt   = 1'b1;
        w_owner    = OWN_BG;
        w_gnt_addr = bg_addr;
      end else if (spr_req) begin
        w_spr_gnt  = 1'b1;
        w_owner    = OWN_SPR;
        w_gnt_addr = spr_addr;
      end else if (w_cpu_pend) begin
        w_cpu_gnt  = 1'b1;
        w_owner    = OWN_CPU;
        w_gnt_addr = w_cpu_addr;
      end
    end
  end

  assign w_any_gnt = w_bg_gnt | w_spr_gnt | w_cpu_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vram_addr  <= '0;
      r_vram_we    <= 1'b0;
      r_vram_wdata <= 8'd0;
      r_tag1       <= OWN_NONE;
      r_tag2       <= OWN_NONE;
    end else begin
      r_vram_we <= w_cpu_gnt && w_cpu_is_wr;
      r_tag2    <= r_tag1;
      // Writes carry no return tag.
      r_tag1    <= (w_cpu_gnt && w_cpu_is_wr) ? OWN_NONE : w_owner;
      if (w_any_gnt) begin
        r_vram_addr <= w_gnt_addr;
      end
      if (w_cpu_gnt && w_cpu_is_wr) begin
        r_vram_wdata <= w_cpu_wdata;
      end
    end
  end

  assign bg_gnt     = w_bg_gnt;
  assign spr_gnt    = w_spr_gnt;
  assign bg_rvalid  = (r_tag2 == OWN_BG);
  assign spr_rvalid = (r_tag2 == OWN_SPR);
  assign vram_addr  = r_vram_addr;
  assign vram_we    = r_vram_we;
  assign vram_wdata = r_vram_wdata;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboarded bench for vram_arbiter with a behavioural synchronous-read VRAM.
module tb_vram_arbiter;

  localparam int AW = 14;
  localparam int SRC_BG  = 1;
  localparam int SRC_SPR = 2;
  localparam int SRC_CPU = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          bg_req, spr_req, cpu_wr, cpu_rd;
  logic [AW-1:0] bg_addr, spr_addr, cpu_addr;
  logic [7:0]    cpu_wdata;
  logic          bg_gnt, bg_rvalid, spr_gnt, spr_rvalid;
  logic          cpu_busy, cpu_rd_valid;
  logic [7:0]    cpu_rdata;
  logic [AW-1:0] vram_addr;
  logic          vram_we;
  logic [7:0]    vram_wdata;
  logic [7:0]    vram_rdata = 8'd0;

  logic [7:0]    mem [0:(1<<AW)-1];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    int         src;
    logic [7:0] dat;
    int         at;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  vram_arbiter #(.CPU_MAX_WAIT(8), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .bg_req       (bg_req),
    .bg_addr      (bg_addr),
    .bg_gnt       (bg_gnt),
    .bg_rvalid    (bg_rvalid),
    .spr_req      (spr_req),
    .spr_addr     (spr_addr),
    .spr_gnt      (spr_gnt),
    .spr_rvalid   (spr_rvalid),
    .cpu_wr       (cpu_wr),
    .cpu_rd       (cpu_rd),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_busy     (cpu_busy),
    .cpu_rdata    (cpu_rdata),
    .cpu_rd_valid (cpu_rd_valid),
    .vram_addr    (vram_addr),
    .vram_we      (vram_we),
    .vram_wdata   (vram_wdata),
    .vram_rdata   (vram_rdata)
  );

  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic expect_rd(input int src, input logic [7:0] dat, input int at);
    exp_t e;
    e.src = src;
    e.dat = dat;
    e.at  = at;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // Every return pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    int   n_hi;
    int   src;
    logic [7:0] d;
    exp_t e;
    n_hi = int'(bg_rvalid) + int'(spr_rvalid) + int'(cpu_rd_valid);
    if (n_hi > 1) begin
      check("rv_onehot", n_hi, 1);
    end else if (n_hi == 1) begin
      src = bg_rvalid ? SRC_BG : (spr_rvalid ? SRC_SPR : SRC_CPU);
      d   = cpu_rd_valid ? cpu_rdata : vram_rdata;
      if (sb.size() == 0) begin
        check("rv_unexpected", src, 0);
      end else begin
        e = sb.pop_front();
        check("rv_src", src, e.src);
        check("rv_dat", d, e.dat);
        check("rv_cycle", cyc, e.at);
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'd0;
    mem[14'h3800] = 8'hA5;
    mem[14'h3F00] = 8'h5A;

    // Reset with every display request high.
    rst = 1'b1; bg_req = 1'b1; spr_req = 1'b1;
    bg_addr = 14'h3800; spr_addr = 14'h3F00;
    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; cpu_wdata = 8'd0;
    repeat (3) tick();
    settle();
    check("rst_gnts", {30'd0, bg_gnt, spr_gnt}, 0);
    check("rst_flags", {27'd0, bg_rvalid, spr_rvalid, cpu_rd_valid, cpu_busy, vram_we}, 0);
    check("rst_vram_addr", vram_addr, 0);
    check("rst_vram_wdata", vram_wdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    tick();
    rst = 1'b0;
    settle();
    check("first_bg_gnt", bg_gnt, 1);
    check("first_spr_gnt", spr_gnt, 0);
    expect_rd(SRC_BG, 8'hA5, cyc + 2);
    tick();
    bg_req = 1'b0; spr_req = 1'b0;
    repeat (4) tick();

    // Simultaneous bg/spr requests.
    bg_req = 1'b1; spr_req = 1'b1;
    settle();
    check("dual_bg_gnt", bg_gnt, 1);
    check("dual_spr_wait", spr_gnt, 0);
    expect_rd(SRC_BG, 8'hA5, cyc + 2);
    tick();
    bg_req = 1'b0;
    settle();
    check("dual_spr_gnt", spr_gnt, 1);
    check("dual_bg_idle", bg_gnt, 0);
    expect_rd(SRC_SPR, 8'h5A, cyc + 2);
    tick();
    spr_req = 1'b0;
    repeat (4) tick();

    // CPU write then read-back with no display traffic.
    cpu_wr = 1'b1; cpu_addr = 14'h0123; cpu_wdata = 8'h7E;
    settle();
    check("wr_idle_busy", cpu_busy, 0);
    tick();
    cpu_wr = 1'b0;
    settle();
    check("wr_busy", cpu_busy, 1);
    check("wr_we_not_yet", vram_we, 0);
    tick();
    settle();
    check("wr_we", vram_we, 1);
    check("wr_addr", vram_addr, 14'h0123);
    check("wr_data", vram_wdata, 8'h7E);
    check("wr_done_busy", cpu_busy, 0);
    tick();
    settle();
    check("wr_we_pulse", vram_we, 0);
    cpu_rd = 1'b1; cpu_addr = 14'h0123;
    expect_rd(SRC_CPU, 8'h7E, cyc + 3);
    tick();
    cpu_rd = 1'b0;
    repeat (4) tick();
    settle();
    check("rd_hold", cpu_rdata, 8'h7E);

    // Starvation: bg held continuously while the CPU writes.
    bg_req = 1'b1; bg_addr = 14'h0010;
    cpu_wr = 1'b1; cpu_addr = 14'h0200; cpu_wdata = 8'h33;
    settle();
    check("starve_bg_first", bg_gnt, 1);
    expect_rd(SRC_BG, 8'h00, cyc + 2);
    for (int k = 1; k <= 8; k++) begin
      tick();
      cpu_wr = 1'b0;
      settle();
      check("starve_bg_gnt", bg_gnt, 1);
      expect_rd(SRC_BG, 8'h00, cyc + 2);
    end
    tick();
    settle();
    check("starve_cpu_wins", bg_gnt, 0);
    check("starve_busy", cpu_busy, 1);
    tick();
    settle();
    check("starve_bg_resume", bg_gnt, 1);
    check("starve_we", vram_we, 1);
    check("starve_addr", vram_addr, 14'h0200);
    check("starve_data", vram_wdata, 8'h33);
    expect_rd(SRC_BG, 8'h00, cyc + 2);
    tick();
    bg_req = 1'b0;
    repeat (4) tick();

    // Write+read together, then a strobe while busy.
    cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_addr = 14'h0300; cpu_wdata = 8'h44;
    tick();
    cpu_rd = 1'b0; cpu_wr = 1'b1; cpu_addr = 14'h0301; cpu_wdata = 8'h55;
    settle();
    check("both_busy", cpu_busy, 1);
    tick();
    cpu_wr = 1'b0;
    settle();
    check("both_we", vram_we, 1);
    check("both_addr", vram_addr, 14'h0300);
    check("both_data", vram_wdata, 8'h44);
    tick();
    settle();
    check("both_no_2nd_we", vram_we, 0);
    check("both_idle", cpu_busy, 0);
    check("both_data_held", vram_wdata, 8'h44);
    repeat (4) tick();

    // Reset the cycle after a sprite grant with a CPU read buffered.
    spr_req = 1'b1; spr_addr = 14'h3F00;
    cpu_rd = 1'b1; cpu_addr = 14'h0123;
    settle();
    check("rstmid_spr_gnt", spr_gnt, 1);
    tick();
    spr_req = 1'b0; cpu_rd = 1'b0; rst = 1'b1;
    settle();
    check("rstmid_busy_before", cpu_busy, 1);
    tick();
    rst = 1'b0;
    settle();
    check("rstmid_idle", cpu_busy, 0);
    check("rstmid_we", vram_we, 0);
    repeat (6) tick();

    check("sb_drain", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
